// File: rtl/fsm_rtc_seq.sv
// RTC bus sequencer: walks N_REG registers through ADDR/GAP1/DATA/GAP2 phases.
// Optional write support is compiled in with RTC_SEQ_WRITE_EN; otherwise only reads are built.
module fsm_rtc_seq #(
    parameter int N_REG  = 10,
    parameter int IDX_W  = 4,
    parameter int T_ADDR = 8,
    parameter int T_GAP  = 4,
    parameter int T_DATA = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             w_r,
    input  logic             abort,
    output logic             a_d,
    output logic             cs,
    output logic             rd,
    output logic             wr,
    output logic [IDX_W-1:0] sel_idx,
    output logic             dir_en,
    output logic             dat_en,
    output logic             reg_to_rtc,
    output logic             rtc_to_reg,
    output logic             dat_cap,
    output logic             busy,
    output logic             done
);

    typedef enum logic [2:0] {
        IDLE, ADDR, GAP1, DATA, GAP2, DONE
    } state_t;

    typedef struct packed {
        logic a_d;
        logic cs;
        logic rd;
        logic wr;
        logic dir_en;
        logic dat_en;
        logic reg_to_rtc;
        logic rtc_to_reg;
    } bus_t;

    localparam bus_t       BUS_IDLE  = '{a_d: 1'b1, cs: 1'b1, rd: 1'b1, wr: 1'b1, default: 1'b0};
    // Counter counts down to zero, so each phase loads its length minus one.
    localparam logic [7:0] ADDR_LOAD = 8'(T_ADDR - 1);
    localparam logic [7:0] GAP_LOAD  = 8'(T_GAP - 1);
    localparam logic [7:0] DATA_LOAD = 8'(T_DATA - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_REG - 1);

    state_t           state, state_n;
    logic [7:0]       cnt, cnt_n;
    logic [IDX_W-1:0] idx_n;
    logic             mode, mode_n;
    logic             write_req;
    bus_t             bus, bus_n;

`ifdef RTC_SEQ_WRITE_EN
    assign write_req = w_r;
`else
    // Mode is pinned to read; w_r is intentionally left unconnected.
    logic unused_w_r;
    assign unused_w_r = w_r;
    assign write_req  = 1'b0;
`endif

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        idx_n   = sel_idx;
        mode_n  = mode;
        if (state != IDLE && abort) begin
            state_n = IDLE;
            cnt_n   = 8'd0;
        end else begin
            case (state)
                IDLE: if (start && !abort) begin
                    state_n = ADDR;
                    cnt_n   = ADDR_LOAD;
                    idx_n   = '0;
                    mode_n  = write_req;
                end
                ADDR: if (cnt == 8'd0) begin
                    state_n = GAP1;
                    cnt_n   = GAP_LOAD;
                end else cnt_n = cnt - 8'd1;
                GAP1: if (cnt == 8'd0) begin
                    state_n = DATA;
                    cnt_n   = DATA_LOAD;
                end else cnt_n = cnt - 8'd1;
                DATA: if (cnt == 8'd0) begin
                    state_n = GAP2;
                    cnt_n   = GAP_LOAD;
                end else cnt_n = cnt - 8'd1;
                GAP2: if (cnt == 8'd0) begin
                    if (sel_idx == LAST_IDX) begin
                        state_n = DONE;
                        cnt_n   = 8'd0;
                    end else begin
                        state_n = ADDR;
                        cnt_n   = ADDR_LOAD;
                        idx_n   = sel_idx + 1'b1;
                    end
                end else cnt_n = cnt - 8'd1;
                default: begin
                    state_n = IDLE;
                    cnt_n   = 8'd0;
                end
            endcase
        end
    end

    always_comb begin
        bus_n = BUS_IDLE;
        case (state_n)
            ADDR: begin
                bus_n.cs         = 1'b0;
                bus_n.a_d        = 1'b0;
                bus_n.wr         = 1'b0;
                bus_n.dir_en     = 1'b1;
                bus_n.reg_to_rtc = 1'b1;
            end
            DATA: begin
                bus_n.cs     = 1'b0;
                bus_n.dat_en = 1'b1;
`ifdef RTC_SEQ_WRITE_EN
                if (mode_n) begin
                    bus_n.wr         = 1'b0;
                    bus_n.reg_to_rtc = 1'b1;
                end else begin
                    bus_n.rd         = 1'b0;
                    bus_n.rtc_to_reg = 1'b1;
                end
`else
                bus_n.rd         = 1'b0;
                bus_n.rtc_to_reg = 1'b1;
`endif
            end
            default: bus_n = BUS_IDLE;
        endcase
    end

    // Outputs are registered from the next-state decode, so nothing reaches a pin
    // combinationally from start, abort or w_r.
    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= 8'd0;
            sel_idx <= '0;
            mode    <= 1'b0;
            bus     <= BUS_IDLE;
            dat_cap <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            sel_idx <= idx_n;
            mode    <= mode_n;
            bus     <= bus_n;
            dat_cap <= (state_n == DATA) && (cnt_n == 8'd0) && !mode_n;
            busy    <= (state_n != IDLE) && (state_n != DONE);
            done    <= (state_n == DONE);
        end
    end

    assign a_d        = bus.a_d;
    assign cs         = bus.cs;
    assign rd         = bus.rd;
    assign wr         = bus.wr;
    assign dir_en     = bus.dir_en;
    assign dat_en     = bus.dat_en;
    assign reg_to_rtc = bus.reg_to_rtc;
    assign rtc_to_reg = bus.rtc_to_reg;

endmodule

// File: tb/tb_fsm_rtc_seq.sv
// Bench for fsm_rtc_seq: directed scenarios then random start/w_r/abort traffic,
// compared every cycle against a timeline model built from phase lengths.
module tb_fsm_rtc_seq;

    localparam int N  = 10;
    localparam int IW = 4;
    localparam int TA = 8;
    localparam int TG = 4;
    localparam int TD = 8;
    localparam int P  = TA + 2 * TG + TD;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic start = 1'b0, w_r = 1'b0, abort = 1'b0;
    logic a_d, cs, rd, wr, dir_en, dat_en, reg_to_rtc, rtc_to_reg, dat_cap, busy, done;
    logic [IW-1:0] sel_idx;

    logic start2 = 1'b0, abort2 = 1'b0;
    logic s_a_d, s_cs, s_rd, s_wr, s_dir_en, s_dat_en, s_r2r, s_t2r, s_cap, s_busy, s_done;
    logic [0:0] s_idx;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: 0 = idle, 1 = running at cycle t of the sequence, 2 = done cycle.
    int ph = 0;
    int t = 0;
    int idx = 0;
    bit md = 1'b0;

    always #5 clk = ~clk;

    fsm_rtc_seq #(.N_REG(N), .IDX_W(IW), .T_ADDR(TA), .T_GAP(TG), .T_DATA(TD)) u_dut (
        .clk(clk), .reset(reset), .start(start), .w_r(w_r), .abort(abort),
        .a_d(a_d), .cs(cs), .rd(rd), .wr(wr), .sel_idx(sel_idx),
        .dir_en(dir_en), .dat_en(dat_en), .reg_to_rtc(reg_to_rtc), .rtc_to_reg(rtc_to_reg),
        .dat_cap(dat_cap), .busy(busy), .done(done)
    );

    fsm_rtc_seq #(.N_REG(1), .IDX_W(1), .T_ADDR(1), .T_GAP(1), .T_DATA(1)) u_small (
        .clk(clk), .reset(reset), .start(start2), .w_r(1'b0), .abort(abort2),
        .a_d(s_a_d), .cs(s_cs), .rd(s_rd), .wr(s_wr), .sel_idx(s_idx),
        .dir_en(s_dir_en), .dat_en(s_dat_en), .reg_to_rtc(s_r2r), .rtc_to_reg(s_t2r),
        .dat_cap(s_cap), .busy(s_busy), .done(s_done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [31:0] dut_vec();
        return 32'({a_d, cs, rd, wr, dir_en, dat_en, reg_to_rtc, rtc_to_reg,
                    dat_cap, busy, done, sel_idx});
    endfunction

    function automatic logic [31:0] exp_vec();
        logic e_ad = 1'b1, e_cs = 1'b1, e_rd = 1'b1, e_wr = 1'b1;
        logic e_de = 1'b0, e_dt = 1'b0, e_r2r = 1'b0, e_t2r = 1'b0;
        logic e_cap = 1'b0, e_busy = 1'b0, e_done = 1'b0;
        int r;
        if (ph == 1) begin
            e_busy = 1'b1;
            r = (t - 1) % P;
            if (r < TA) begin
                e_cs = 1'b0; e_ad = 1'b0; e_wr = 1'b0; e_de = 1'b1; e_r2r = 1'b1;
            end else if (r >= TA + TG && r < TA + TG + TD) begin
                e_cs = 1'b0; e_dt = 1'b1;
                if (md) begin
                    e_wr = 1'b0; e_r2r = 1'b1;
                end else begin
                    e_rd = 1'b0; e_t2r = 1'b1;
                    e_cap = (r == TA + TG + TD - 1);
                end
            end
        end else if (ph == 2) begin
            e_done = 1'b1;
        end
        return 32'({e_ad, e_cs, e_rd, e_wr, e_de, e_dt, e_r2r, e_t2r,
                    e_cap, e_busy, e_done, IW'(idx)});
    endfunction

    task automatic model_reset();
        ph = 0; t = 0; idx = 0; md = 1'b0;
    endtask

    task automatic model_edge(input bit s, input bit w, input bit a);
        case (ph)
            0: if (s && !a) begin
                ph = 1; t = 1; idx = 0;
`ifdef RTC_SEQ_WRITE_EN
                md = w;
`else
                md = 1'b0;
`endif
            end
            1: begin
                if (a) ph = 0;
                else if (t == N * P) ph = 2;
                else begin
                    t++;
                    idx = (t - 1) / P;
                end
            end
            default: ph = 0;
        endcase
    endtask

    // One clock: drive inputs, advance DUT and model on the edge, compare on the falling edge.
    task automatic cycle(input bit s, input bit w, input bit a, input string tag);
        start = s; w_r = w; abort = a;
        @(posedge clk);
        model_edge(s, w, a);
        @(negedge clk);
        check(tag, dut_vec(), exp_vec());
    endtask

    initial begin
        #12;
        check("reset_state", dut_vec(), exp_vec());
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0, "idle_after_reset");

        // Full read sequence with a stray start at cycle 100 and w_r wiggling.
        cycle(1'b1, 1'b0, 1'b0, "read_start");
        for (int c = 2; c <= 243; c++)
            cycle(c == 100, c[0], 1'b0, "read_seq");
        check("read_done_seen_idle", 32'(ph), 32'd0);

        // Write request (read-only build treats it as a read).
        cycle(1'b1, 1'b1, 1'b0, "write_start");
        for (int c = 2; c <= 243; c++) cycle(1'b0, 1'b0, 1'b0, "write_seq");

        // Abort in cycle 50, then restart from index 0.
        cycle(1'b1, 1'b0, 1'b0, "abort_start");
        for (int c = 2; c <= 49; c++) cycle(1'b0, 1'b0, 1'b0, "pre_abort");
        cycle(1'b0, 1'b0, 1'b1, "abort_hit");
        check("abort_cs_high", 32'(cs), 32'd1);
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b0, "post_abort");
        cycle(1'b1, 1'b0, 1'b0, "restart");
        check("restart_idx0", 32'(sel_idx), 32'd0);
        for (int c = 2; c <= 243; c++) cycle(1'b0, 1'b0, 1'b0, "restart_seq");

        // start and abort together in IDLE.
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b1, "start_with_abort");
        cycle(1'b0, 1'b0, 1'b0, "after_start_abort");

        // Reset between edges in the middle of a DATA phase.
        cycle(1'b1, 1'b0, 1'b0, "rst_start");
        for (int c = 2; c <= 15; c++) cycle(1'b0, 1'b0, 1'b0, "to_data");
        #2 reset = 1'b0;
        #1;
        model_reset();
        check("async_reset", dut_vec(), exp_vec());
        check("async_reset_bus", 32'({cs, rd, wr}), 32'b111);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 6; i++) cycle(1'b0, 1'b1, 1'b0, "quiet_after_reset");

        // Smallest configuration: one register, all phases one cycle.
        start2 = 1'b1;
        cycle(1'b0, 1'b0, 1'b0, "small_kick");
        start2 = 1'b0;
        check("small_c1", 32'({s_busy, s_done, s_cap, s_idx}), 32'b1000);
        for (int c = 2; c <= 6; c++) begin
            cycle(1'b0, 1'b0, 1'b0, "small_main_idle");
            check("small_seq", 32'({s_busy, s_done, s_cap, s_idx}),
                  32'({c <= 4, c == 5, c == 3, 1'b0}));
        end

        // Random traffic.
        for (int i = 0; i < 4000; i++)
            cycle($urandom_range(0, 7) == 0, 1'($urandom), $urandom_range(0, 299) == 0, "random");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
